// File: rtl/lsu_mem_access.sv
// Load/store unit datapath: captures one EXU bundle, issues at most one RAM request,
// aligns store lanes / extracts load lanes, and hands the result to WBU.
module lsu_mem_access #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ARGS_WIDTH = 8
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  input  logic                  i_exu_valid,
  output logic                  o_lsu_ready,
  input  logic [ADDR_WIDTH-1:0] i_exu_pc,
  input  logic [DATA_WIDTH-1:0] i_exu_res,
  input  logic [ARGS_WIDTH-1:0] i_idu_ctr_ram_byt,
  input  logic                  i_idu_ctr_ram_wr_en,
  input  logic                  i_idu_ctr_ram_rd_en,
  input  logic [DATA_WIDTH-1:0] i_gpr_rs2_data,
  input  logic [ARGS_WIDTH-1:0] i_idu_ctr_inst_type,
  output logic                  o_ram_req_valid,
  input  logic                  i_ram_req_ready,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_wr_en,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data,
  output logic [3:0]            o_ram_wr_mask,
  input  logic                  i_ram_rsp_valid,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                  o_lsu_valid,
  input  logic                  i_wbu_ready,
  output logic [ADDR_WIDTH-1:0] o_lsu_pc,
  output logic [DATA_WIDTH-1:0] o_lsu_res,
  output logic [ARGS_WIDTH-1:0] o_lsu_inst_type,
  output logic                  o_lsu_misalign
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [2:0] BytBs = 3'd1;
  localparam logic [2:0] BytBu = 3'd2;
  localparam logic [2:0] BytHs = 3'd3;
  localparam logic [2:0] BytHu = 3'd4;
  localparam logic [2:0] BytW  = 3'd5;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, addr_q;
  logic [DATA_WIDTH-1:0] res_q, res_d, rs2_q;
  logic [ARGS_WIDTH-1:0] inst_type_q;
  logic [2:0]            byt_q;
  logic                  wr_q;
  logic                  misalign_q, misalign_d;

  logic [2:0] byt_in;
  logic [1:0] addr_lo_in;
  logic       mem_in;
  logic       size_fault_in;
  logic       fault_in;
  logic       accept;
  logic       in_req;

  logic [DATA_WIDTH-1:0] rd_shift;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] st_data;
  logic [3:0]            st_mask;

  // Only the low three bits carry the size code.
  logic unused_byt_hi;
  assign unused_byt_hi = ^i_idu_ctr_ram_byt[ARGS_WIDTH-1:3];

  assign byt_in     = i_idu_ctr_ram_byt[2:0];
  assign addr_lo_in = i_exu_res[1:0];
  assign mem_in     = i_idu_ctr_ram_rd_en | i_idu_ctr_ram_wr_en;
  assign accept     = (state_q == StIdle) & i_exu_valid;
  assign in_req     = (state_q == StReq);

  // Classify the incoming access size: illegal codes and unaligned H/W fault.
  always_comb begin
    size_fault_in = 1'b1;
    case (byt_in)
      BytBs, BytBu: size_fault_in = 1'b0;
      BytHs, BytHu: size_fault_in = addr_lo_in[0];
      BytW:         size_fault_in = |addr_lo_in;
      default:      size_fault_in = 1'b1;
    endcase
  end

  assign fault_in = mem_in & size_fault_in;

  // Bring the addressed lane down to bit 0, then extend per size code.
  assign rd_shift = i_ram_rd_data >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = rd_shift;
    case (byt_q)
      BytBs:   load_ext = {{(DATA_WIDTH-8){rd_shift[7]}}, rd_shift[7:0]};
      BytBu:   load_ext = {{(DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
      BytHs:   load_ext = {{(DATA_WIDTH-16){rd_shift[15]}}, rd_shift[15:0]};
      BytHu:   load_ext = {{(DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Store lanes: data replicated across the word, mask selects the addressed bytes.
  always_comb begin
    st_data = i_gpr_rs2_data & '0;
    st_mask = 4'b0000;
    case (byt_q)
      BytBs, BytBu: begin
        st_data = {4{rs2_q[7:0]}};
        st_mask = 4'b0001 << addr_q[1:0];
      end
      BytHs, BytHu: begin
        st_data = {2{rs2_q[15:0]}};
        st_mask = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_data = rs2_q;
        st_mask = 4'b1111;
      end
    endcase
  end

  // Next-state and result selection for IDLE->REQ->WAIT->DONE.
  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    misalign_d = misalign_q;
    case (state_q)
      StIdle: begin
        if (i_exu_valid) begin
          if (!mem_in) begin
            res_d      = i_exu_res;
            misalign_d = 1'b0;
            state_d    = StDone;
          end else if (fault_in) begin
            res_d      = '0;
            misalign_d = 1'b1;
            state_d    = StDone;
          end else begin
            res_d      = '0;
            misalign_d = 1'b0;
            state_d    = StReq;
          end
        end
      end
      StReq: begin
        if (i_ram_req_ready) begin
          if (wr_q) begin
            res_d   = '0;
            state_d = StDone;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (i_ram_rsp_valid) begin
          res_d   = load_ext;
          state_d = StDone;
        end
      end
      StDone: begin
        if (i_wbu_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, result and captured bundle; bundle only loads on accept so it is stable after.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state_q     <= StIdle;
      res_q       <= '0;
      misalign_q  <= 1'b0;
      pc_q        <= '0;
      addr_q      <= '0;
      rs2_q       <= '0;
      inst_type_q <= '0;
      byt_q       <= 3'd0;
      wr_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      misalign_q <= misalign_d;
      if (accept) begin
        pc_q        <= i_exu_pc;
        addr_q      <= i_exu_res[ADDR_WIDTH-1:0];
        rs2_q       <= i_gpr_rs2_data;
        inst_type_q <= i_idu_ctr_inst_type;
        byt_q       <= byt_in;
        // A bundle with both enables set behaves as a store.
        wr_q        <= i_idu_ctr_ram_wr_en;
      end
    end
  end

  assign o_lsu_ready     = (state_q == StIdle) & i_sys_rst_n;
  assign o_lsu_valid     = (state_q == StDone);
  assign o_lsu_pc        = pc_q;
  assign o_lsu_res       = res_q;
  assign o_lsu_inst_type = inst_type_q;
  assign o_lsu_misalign  = misalign_q;

  assign o_ram_req_valid = in_req;
  assign o_ram_addr      = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign o_ram_wr_en     = in_req & wr_q;
  assign o_ram_wr_data   = (in_req & wr_q) ? st_data : '0;
  assign o_ram_wr_mask   = (in_req & wr_q) ? st_mask : 4'b0000;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: directed scenarios plus randomized transactions checked
// against an arithmetic model of sizes, alignment, lanes and latency.
module tb_lsu_mem_access;

  logic        i_sys_clk = 1'b0;
  logic        i_sys_rst_n;
  logic        i_exu_valid;
  logic        o_lsu_ready;
  logic [31:0] i_exu_pc;
  logic [31:0] i_exu_res;
  logic [7:0]  i_idu_ctr_ram_byt;
  logic        i_idu_ctr_ram_wr_en;
  logic        i_idu_ctr_ram_rd_en;
  logic [31:0] i_gpr_rs2_data;
  logic [7:0]  i_idu_ctr_inst_type;
  logic        o_ram_req_valid;
  logic        i_ram_req_ready;
  logic [31:0] o_ram_addr;
  logic        o_ram_wr_en;
  logic [31:0] o_ram_wr_data;
  logic [3:0]  o_ram_wr_mask;
  logic        i_ram_rsp_valid;
  logic [31:0] i_ram_rd_data;
  logic        o_lsu_valid;
  logic        i_wbu_ready;
  logic [31:0] o_lsu_pc;
  logic [31:0] o_lsu_res;
  logic [7:0]  o_lsu_inst_type;
  logic        o_lsu_misalign;

  int tests_run = 0;
  int failed    = 0;

  // Observations collected by run_txn.
  bit          obs_ready_before, obs_ready_after, obs_valid_after;
  bit          obs_req_seen, obs_req_stable, obs_ram_leak, obs_busy_ready;
  bit          obs_valid_seen, obs_res_stable, obs_timeout;
  int          obs_lat;
  logic [31:0] obs_addr, obs_wdata, obs_res, obs_pc;
  logic [3:0]  obs_mask;
  logic        obs_wr_en, obs_mis;
  logic [7:0]  obs_inst;

  lsu_mem_access dut (
    .i_sys_clk           (i_sys_clk),
    .i_sys_rst_n         (i_sys_rst_n),
    .i_exu_valid         (i_exu_valid),
    .o_lsu_ready         (o_lsu_ready),
    .i_exu_pc            (i_exu_pc),
    .i_exu_res           (i_exu_res),
    .i_idu_ctr_ram_byt   (i_idu_ctr_ram_byt),
    .i_idu_ctr_ram_wr_en (i_idu_ctr_ram_wr_en),
    .i_idu_ctr_ram_rd_en (i_idu_ctr_ram_rd_en),
    .i_gpr_rs2_data      (i_gpr_rs2_data),
    .i_idu_ctr_inst_type (i_idu_ctr_inst_type),
    .o_ram_req_valid     (o_ram_req_valid),
    .i_ram_req_ready     (i_ram_req_ready),
    .o_ram_addr          (o_ram_addr),
    .o_ram_wr_en         (o_ram_wr_en),
    .o_ram_wr_data       (o_ram_wr_data),
    .o_ram_wr_mask       (o_ram_wr_mask),
    .i_ram_rsp_valid     (i_ram_rsp_valid),
    .i_ram_rd_data       (i_ram_rd_data),
    .o_lsu_valid         (o_lsu_valid),
    .i_wbu_ready         (i_wbu_ready),
    .o_lsu_pc            (o_lsu_pc),
    .o_lsu_res           (o_lsu_res),
    .o_lsu_inst_type     (o_lsu_inst_type),
    .o_lsu_misalign      (o_lsu_misalign)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  // ---------------- reference model ----------------
  function automatic int unsigned size_bytes(input logic [2:0] c);
    case (c)
      3'd1, 3'd2: return 1;
      3'd3, 3'd4: return 2;
      3'd5:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_fault(input bit mem, input logic [2:0] c, input logic [31:0] a);
    int unsigned sz;
    if (!mem) return 1'b0;
    sz = size_bytes(c);
    if (sz == 0) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] c, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] v;
    v = w / (32'd1 << (8 * (a % 4)));
    case (c)
      3'd1: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd2: v = v % 256;
      3'd3: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = v % 65536;
      default: ;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] c, input logic [31:0] a);
    int unsigned m;
    m = ((1 << size_bytes(c)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] c, input logic [31:0] rs2);
    case (size_bytes(c))
      1:       return (rs2 % 256) * 32'h0101_0101;
      2:       return (rs2 % 65536) * 32'h0001_0001;
      default: return rs2;
    endcase
  endfunction

  // ---------------- transaction driver (no checking) ----------------
  task automatic run_txn(input logic [31:0] pc, input logic [31:0] res, input logic [7:0] byt,
                         input logic wr, input logic rd, input logic [31:0] rs2,
                         input logic [7:0] inst, input int req_wait, input int rsp_wait,
                         input int wbu_wait, input logic [31:0] rd_word);
    int cyc, rq, rs, wb;
    bit req_acc, rsp_sent, wbu_fired, done;
    cyc = 0; rq = 0; rs = 0; wb = 0;
    req_acc = 0; rsp_sent = 0; wbu_fired = 0; done = 0;
    obs_req_seen = 0; obs_req_stable = 1; obs_ram_leak = 0; obs_busy_ready = 0;
    obs_valid_seen = 0; obs_res_stable = 1; obs_timeout = 0; obs_lat = -1;
    obs_ready_after = 0; obs_valid_after = 1;
    obs_addr = '0; obs_wdata = '0; obs_mask = '0; obs_wr_en = 0;
    obs_res = '0; obs_pc = '0; obs_inst = '0; obs_mis = 0;
    @(negedge i_sys_clk);
    obs_ready_before    = o_lsu_ready;
    i_exu_valid         = 1'b1;
    i_exu_pc            = pc;
    i_exu_res           = res;
    i_idu_ctr_ram_byt   = byt;
    i_idu_ctr_ram_wr_en = wr;
    i_idu_ctr_ram_rd_en = rd;
    i_gpr_rs2_data      = rs2;
    i_idu_ctr_inst_type = inst;
    @(negedge i_sys_clk);
    // Scramble the bundle so any late sampling shows up.
    i_exu_valid         = 1'b0;
    i_exu_pc            = $urandom();
    i_exu_res           = $urandom();
    i_idu_ctr_ram_byt   = 8'($urandom());
    i_gpr_rs2_data      = $urandom();
    i_idu_ctr_inst_type = 8'($urandom());
    cyc = 1;
    while (!done && cyc < 60) begin
      i_ram_req_ready = 1'b0;
      i_ram_rsp_valid = 1'b0;
      i_ram_rd_data   = $urandom();
      if (wbu_fired) begin
        obs_ready_after = o_lsu_ready;
        obs_valid_after = o_lsu_valid;
        i_wbu_ready     = 1'b0;
        done            = 1;
      end else begin
        if (o_lsu_ready) obs_busy_ready = 1;
        if (!o_ram_req_valid && (o_ram_wr_en || o_ram_addr != 0 || o_ram_wr_data != 0 ||
                                 o_ram_wr_mask != 0)) obs_ram_leak = 1;
        if (o_ram_req_valid) begin
          if (!obs_req_seen) begin
            obs_req_seen = 1;
            obs_addr = o_ram_addr; obs_wr_en = o_ram_wr_en;
            obs_wdata = o_ram_wr_data; obs_mask = o_ram_wr_mask;
          end else if ({o_ram_addr, o_ram_wr_en, o_ram_wr_data, o_ram_wr_mask} !==
                       {obs_addr, obs_wr_en, obs_wdata, obs_mask}) begin
            obs_req_stable = 0;
          end
          if (rq >= req_wait) begin i_ram_req_ready = 1'b1; req_acc = 1; end
          rq++;
        end else if (req_acc && !rsp_sent && !o_lsu_valid) begin
          if (rs >= rsp_wait) begin
            i_ram_rsp_valid = 1'b1; i_ram_rd_data = rd_word; rsp_sent = 1;
          end
          rs++;
        end
        if (o_lsu_valid) begin
          if (!obs_valid_seen) begin
            obs_valid_seen = 1; obs_lat = cyc;
            obs_res = o_lsu_res; obs_pc = o_lsu_pc;
            obs_inst = o_lsu_inst_type; obs_mis = o_lsu_misalign;
          end else if ({o_lsu_res, o_lsu_pc, o_lsu_inst_type, o_lsu_misalign} !==
                       {obs_res, obs_pc, obs_inst, obs_mis}) begin
            obs_res_stable = 0;
          end
          if (wb >= wbu_wait) begin i_wbu_ready = 1'b1; wbu_fired = 1; end
          wb++;
        end
        @(negedge i_sys_clk);
        cyc++;
      end
    end
    obs_timeout     = !done;
    i_ram_req_ready = 1'b0;
    i_ram_rsp_valid = 1'b0;
    i_wbu_ready     = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_sys_rst_n = 1'b0;
    repeat (2) @(negedge i_sys_clk);
    tests_run++;
    if (o_lsu_ready !== 1'b0) begin
      failed++; $display("FAIL reset_ready: got %b want 0", o_lsu_ready);
    end
    tests_run++;
    if ({o_lsu_valid, o_ram_req_valid, o_lsu_pc, o_lsu_res, o_lsu_inst_type, o_lsu_misalign,
         o_ram_addr, o_ram_wr_en, o_ram_wr_data, o_ram_wr_mask} !== '0) begin
      failed++; $display("FAIL reset_outputs: valid=%b req=%b pc=%h res=%h want all 0",
                         o_lsu_valid, o_ram_req_valid, o_lsu_pc, o_lsu_res);
    end
    i_sys_rst_n = 1'b1;
    @(negedge i_sys_clk);
    tests_run++;
    if (o_lsu_ready !== 1'b1) begin
      failed++; $display("FAIL reset_release_ready: got %b want 1", o_lsu_ready);
    end
  endtask

  task automatic test_nonmem();
    run_txn(32'h8000_0100, 32'h1234_5678, 8'd5, 1'b0, 1'b0, 32'hDEAD_BEEF, 8'h2C, 0, 0, 0, '0);
    tests_run++;
    if (obs_lat !== 1) begin failed++; $display("FAIL nonmem_lat: got %0d want 1", obs_lat); end
    tests_run++;
    if ({obs_res, obs_pc, obs_inst, obs_mis} !== {32'h1234_5678, 32'h8000_0100, 8'h2C, 1'b0})
    begin
      failed++; $display("FAIL nonmem_result: got res=%h pc=%h inst=%h mis=%b want 12345678 80000100 2c 0",
                         obs_res, obs_pc, obs_inst, obs_mis);
    end
    tests_run++;
    if ({obs_req_seen, obs_ready_after, obs_valid_after} !== 3'b010) begin
      failed++; $display("FAIL nonmem_handshake: req=%b ready_after=%b valid_after=%b want 0 1 0",
                         obs_req_seen, obs_ready_after, obs_valid_after);
    end
  endtask

  task automatic test_store_byte();
    run_txn(32'h8000_0200, 32'h8000_0003, 8'd1, 1'b1, 1'b0, 32'h0000_00AB, 8'h23, 0, 0, 0, '0);
    tests_run++;
    if ({obs_req_seen, obs_addr, obs_wr_en, obs_mask, obs_wdata} !==
        {1'b1, 32'h8000_0000, 1'b1, 4'b1000, 32'hABAB_ABAB}) begin
      failed++; $display("FAIL store_b_req: seen=%b addr=%h we=%b mask=%b data=%h want 1 80000000 1 1000 abababab",
                         obs_req_seen, obs_addr, obs_wr_en, obs_mask, obs_wdata);
    end
    tests_run++;
    if ({obs_lat, obs_res, obs_mis} !== {32'd2, 32'h0, 1'b0}) begin
      failed++; $display("FAIL store_b_result: lat=%0d res=%h mis=%b want 2 0 0",
                         obs_lat, obs_res, obs_mis);
    end
  endtask

  task automatic test_load();
    run_txn(32'h8000_0300, 32'h8000_0001, 8'd1, 1'b0, 1'b1, '0, 8'h03, 0, 0, 0, 32'h0000_8000);
    tests_run++;
    if ({obs_res, obs_lat, obs_addr, obs_wr_en} !==
        {32'hFFFF_FF80, 32'd3, 32'h8000_0000, 1'b0}) begin
      failed++; $display("FAIL load_bs: res=%h lat=%0d addr=%h we=%b want ffffff80 3 80000000 0",
                         obs_res, obs_lat, obs_addr, obs_wr_en);
    end
    run_txn(32'h8000_0304, 32'h8000_0042, 8'd4, 1'b0, 1'b1, '0, 8'h03, 0, 1, 0, 32'hBEEF_0000);
    tests_run++;
    if ({obs_res, obs_lat, obs_addr} !== {32'h0000_BEEF, 32'd4, 32'h8000_0040}) begin
      failed++; $display("FAIL load_hu: res=%h lat=%0d addr=%h want 0000beef 4 80000040",
                         obs_res, obs_lat, obs_addr);
    end
  endtask

  task automatic test_fault();
    run_txn(32'h8000_0400, 32'h8000_0002, 8'd5, 1'b0, 1'b1, '0, 8'h03, 0, 0, 0, 32'h1111_1111);
    tests_run++;
    if ({obs_mis, obs_res, obs_req_seen, obs_lat} !== {1'b1, 32'h0, 1'b0, 32'd1}) begin
      failed++; $display("FAIL fault_w: mis=%b res=%h req=%b lat=%0d want 1 0 0 1",
                         obs_mis, obs_res, obs_req_seen, obs_lat);
    end
    run_txn(32'h8000_0404, 32'h8000_0000, 8'd6, 1'b1, 1'b0, 32'h5, 8'h23, 0, 0, 0, '0);
    tests_run++;
    if ({obs_mis, obs_req_seen} !== 2'b10) begin
      failed++; $display("FAIL fault_code: mis=%b req=%b want 1 0", obs_mis, obs_req_seen);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] word;
    word = $urandom();
    run_txn(32'h8000_0500, 32'h8000_0010, 8'd5, 1'b0, 1'b1, '0, 8'h03, 3, 2, 2, word);
    tests_run++;
    if (obs_timeout !== 1'b0) begin failed++; $display("FAIL bp_timeout: got 1 want 0"); end
    tests_run++;
    if ({obs_req_stable, obs_res_stable, obs_ram_leak, obs_busy_ready} !== 4'b1100) begin
      failed++; $display("FAIL bp_stable: req_stable=%b res_stable=%b leak=%b busy_ready=%b want 1 1 0 0",
                         obs_req_stable, obs_res_stable, obs_ram_leak, obs_busy_ready);
    end
    tests_run++;
    if ({obs_res, obs_lat} !== {word, 32'd8}) begin
      failed++; $display("FAIL bp_result: res=%h lat=%0d want %h 8", obs_res, obs_lat, word);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge i_sys_clk);
    i_exu_valid = 1'b1; i_exu_pc = 32'h8000_0600; i_exu_res = 32'h8000_0020;
    i_idu_ctr_ram_byt = 8'd5; i_idu_ctr_ram_rd_en = 1'b1; i_idu_ctr_ram_wr_en = 1'b0;
    i_idu_ctr_inst_type = 8'h03;
    @(negedge i_sys_clk);
    i_exu_valid = 1'b0;
    tests_run++;
    if (o_ram_req_valid !== 1'b1) begin
      failed++; $display("FAIL mid_req: got %b want 1", o_ram_req_valid);
    end
    i_ram_req_ready = 1'b1;
    @(negedge i_sys_clk);
    i_ram_req_ready = 1'b0;
    i_sys_rst_n = 1'b0;
    @(negedge i_sys_clk);
    tests_run++;
    if ({o_lsu_ready, o_lsu_valid, o_ram_req_valid, o_lsu_pc, o_lsu_res, o_lsu_inst_type,
         o_lsu_misalign, o_ram_addr, o_ram_wr_en, o_ram_wr_data, o_ram_wr_mask} !== '0) begin
      failed++; $display("FAIL mid_reset_outputs: ready=%b valid=%b pc=%h inst=%h want all 0",
                         o_lsu_ready, o_lsu_valid, o_lsu_pc, o_lsu_inst_type);
    end
    i_sys_rst_n = 1'b1;
    @(negedge i_sys_clk);
    tests_run++;
    if ({o_lsu_ready, o_lsu_valid} !== 2'b10) begin
      failed++; $display("FAIL mid_reset_idle: ready=%b valid=%b want 1 0", o_lsu_ready, o_lsu_valid);
    end
    run_txn(32'h8000_0700, 32'hCAFE_F00D, 8'd0, 1'b0, 1'b0, '0, 8'h13, 0, 0, 0, '0);
    tests_run++;
    if ({obs_res, obs_lat} !== {32'hCAFE_F00D, 32'd1}) begin
      failed++; $display("FAIL mid_reset_next: res=%h lat=%0d want cafef00d 1", obs_res, obs_lat);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc, res, rs2, word, exp_res;
      logic [7:0]  byt, inst;
      logic        wr, rd;
      bit          mem, flt;
      int          rqw, rsw, wbw, exp_lat;
      pc = $urandom(); rs2 = $urandom(); word = $urandom(); inst = 8'($urandom());
      res = $urandom();
      byt = {5'($urandom()), 3'($urandom_range(0, 7))};
      wr = 1'($urandom()); rd = 1'($urandom());
      rqw = $urandom_range(0, 3); rsw = $urandom_range(0, 3); wbw = $urandom_range(0, 3);
      mem = wr || rd;
      flt = model_fault(mem, byt[2:0], res);
      if (!mem) begin exp_res = res; exp_lat = 1; end
      else if (flt) begin exp_res = 0; exp_lat = 1; end
      else if (wr) begin exp_res = 0; exp_lat = 2 + rqw; end
      else begin exp_res = model_load(byt[2:0], res, word); exp_lat = 3 + rqw + rsw; end
      run_txn(pc, res, byt, wr, rd, rs2, inst, rqw, rsw, wbw, word);
      tests_run++;
      if ({obs_timeout, obs_req_seen} !== {1'b0, mem && !flt}) begin
        failed++; $display("FAIL rand_req[%0d]: timeout=%b req=%b want 0 %b",
                           n, obs_timeout, obs_req_seen, mem && !flt);
      end
      if (obs_req_seen && mem && !flt) begin
        tests_run++;
        if ({obs_addr, obs_wr_en} !== {res & 32'hFFFF_FFFC, wr}) begin
          failed++; $display("FAIL rand_addr[%0d]: addr=%h we=%b want %h %b",
                             n, obs_addr, obs_wr_en, res & 32'hFFFF_FFFC, wr);
        end
        if (wr) begin
          tests_run++;
          if ({obs_mask, obs_wdata} !== {model_mask(byt[2:0], res), model_wdata(byt[2:0], rs2)})
          begin
            failed++; $display("FAIL rand_lanes[%0d]: mask=%b data=%h want %b %h", n, obs_mask,
                               obs_wdata, model_mask(byt[2:0], res), model_wdata(byt[2:0], rs2));
          end
        end
      end
      tests_run++;
      if ({obs_res, obs_mis, obs_pc, obs_inst} !== {exp_res, flt, pc, inst}) begin
        failed++; $display("FAIL rand_result[%0d]: res=%h mis=%b pc=%h inst=%h want %h %b %h %h",
                           n, obs_res, obs_mis, obs_pc, obs_inst, exp_res, flt, pc, inst);
      end
      tests_run++;
      if (obs_lat !== exp_lat) begin
        failed++; $display("FAIL rand_lat[%0d]: got %0d want %0d", n, obs_lat, exp_lat);
      end
      tests_run++;
      if ({obs_req_stable, obs_res_stable, obs_ram_leak, obs_busy_ready, obs_ready_before,
           obs_ready_after, obs_valid_after} !== 7'b1100110) begin
        failed++; $display("FAIL rand_protocol[%0d]: rs=%b vs=%b leak=%b busy=%b rb=%b ra=%b va=%b",
                           n, obs_req_stable, obs_res_stable, obs_ram_leak, obs_busy_ready,
                           obs_ready_before, obs_ready_after, obs_valid_after);
      end
    end
  endtask

  initial begin
    i_sys_rst_n = 1'b0; i_exu_valid = 1'b0; i_exu_pc = '0; i_exu_res = '0;
    i_idu_ctr_ram_byt = '0; i_idu_ctr_ram_wr_en = 1'b0; i_idu_ctr_ram_rd_en = 1'b0;
    i_gpr_rs2_data = '0; i_idu_ctr_inst_type = '0; i_ram_req_ready = 1'b0;
    i_ram_rsp_valid = 1'b0; i_ram_rd_data = '0; i_wbu_ready = 1'b0;
    test_reset();
    test_nonmem();
    test_store_byte();
    test_load();
    test_fault();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
